// File: rtl/square_wave_calc_pkg.sv
// square_wave_calc_pkg: shared defaults and FSM state encoding for the frequency/duty calculator
package square_wave_calc_pkg;
  localparam int unsigned PLL_FREQ_DEF   = 200_000_000;
  localparam int unsigned DIV_W_DEF      = 48;
  localparam int unsigned DUTY_SCALE_DEF = 1000;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DIV_F = 3'd2,
    ST_DIV_D = 3'd3,
    ST_DONE  = 3'd4
  } state_t;
endpackage

// File: rtl/square_wave_calc_seq_divider.sv
// seq_divider: restoring MSB-first divider, start loads and runs the first quotient bit, done pulses DIV_W cycles after start
module seq_divider #(
  parameter int unsigned DIV_W = 48
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DIV_W-1:0] quotient
);
  localparam int CW = $clog2(DIV_W + 1);
  logic [DIV_W-1:0] rem, dvs, rem_src, quo_src, dvs_src, rem_nxt;
  logic [DIV_W:0]   trial;
  logic             ge;
  logic [CW-1:0]    cnt;
  always_comb begin
    rem_src = start ? '0 : rem;
    quo_src = start ? dividend : quotient;
    dvs_src = start ? divisor : dvs;
    trial   = {rem_src, quo_src[DIV_W-1]};
    ge      = trial >= {1'b0, dvs_src};
    rem_nxt = ge ? DIV_W'(trial - {1'b0, dvs_src}) : trial[DIV_W-1:0];
  end
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      cnt      <= '0;
      rem      <= '0;
      dvs      <= '0;
      quotient <= '0;
    end else begin
      done <= 1'b0;
      if (start || busy) begin
        rem      <= rem_nxt;
        quotient <= {quo_src[DIV_W-2:0], ge};
      end
      if (start) begin
        dvs  <= divisor;
        cnt  <= CW'(DIV_W - 1);
        busy <= 1'b1;
      end else if (busy) begin
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/square_wave_calc.sv
// square_wave_calc: turns one measurement (cycles, period ticks, high ticks) into freq_hz/duty_pm with flags via one shared divider
module square_wave_calc
  import square_wave_calc_pkg::*;
#(
  parameter int unsigned PLL_FREQ   = PLL_FREQ_DEF,
  parameter int unsigned DIV_W      = DIV_W_DEF,
  parameter int unsigned DUTY_SCALE = DUTY_SCALE_DEF
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        meas_valid,
  input  logic [15:0] meas_cycles,
  input  logic [31:0] meas_period,
  input  logic [31:0] meas_high,
  output logic        busy,
  output logic        result_valid,
  output logic [31:0] freq_hz,
  output logic [9:0]  duty_pm,
  output logic        err_div0,
  output logic        sat,
  output logic        overrun
);
  state_t           state;
  logic [15:0]      cyc_q;
  logic [31:0]      per_q, hi_q, freq_pend;
  logic             sat_pend;
  logic [DIV_W-1:0] prod_f, prod_d, div_dividend, div_quo;
  logic             div_start, div_busy, div_done;
  always_comb begin
    prod_f       = DIV_W'(PLL_FREQ) * DIV_W'(cyc_q);
    prod_d       = DIV_W'(hi_q) * DIV_W'(DUTY_SCALE);
    div_dividend = state == ST_LOAD ? prod_f : prod_d;
    div_start    = (state == ST_LOAD && per_q != '0) || (state == ST_DIV_F && div_done && !div_busy);
  end
  seq_divider #(.DIV_W(DIV_W)) u_div (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (div_start),
    .dividend  (div_dividend),
    .divisor   (DIV_W'(per_q)),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo)
  );
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state        <= ST_IDLE;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
      err_div0     <= 1'b0;
      sat          <= 1'b0;
      freq_hz      <= '0;
      duty_pm      <= '0;
      cyc_q        <= '0;
      per_q        <= '0;
      hi_q         <= '0;
      freq_pend    <= '0;
      sat_pend     <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      overrun      <= meas_valid && state != ST_IDLE;
      case (state)
        ST_IDLE: if (meas_valid) begin
          cyc_q <= meas_cycles;
          per_q <= meas_period;
          hi_q  <= meas_high;
          busy  <= 1'b1;
          state <= ST_LOAD;
        end
        ST_LOAD: if (per_q == '0) begin
          err_div0     <= 1'b1;
          sat          <= 1'b0;
          freq_hz      <= '0;
          duty_pm      <= '0;
          result_valid <= 1'b1;
          state        <= ST_DONE;
        end else state <= ST_DIV_F;
        ST_DIV_F: if (div_done) begin
          sat_pend  <= |div_quo[DIV_W-1:32];
          freq_pend <= |div_quo[DIV_W-1:32] ? '1 : div_quo[31:0];
          state     <= ST_DIV_D;
        end
        ST_DIV_D: if (div_done) begin
          freq_hz      <= freq_pend;
          sat          <= sat_pend;
          duty_pm      <= hi_q >= per_q ? 10'(DUTY_SCALE) : div_quo[9:0];
          err_div0     <= 1'b0;
          result_valid <= 1'b1;
          state        <= ST_DONE;
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
